// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: feeds matrixAccelerator lanes group by group from a
// host-loaded operand buffer, then collects the final accumulate.
module conv_job_sequencer #(
  parameter int INPUT_PORT_COUNT = 3,
  parameter int BIT_LENGTH = 16,
  parameter int MAX_GROUPS = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic Clk,
  input  logic Rst,
  input  logic wr_en,
  input  logic [$clog2(INPUT_PORT_COUNT*MAX_GROUPS)-1:0] wr_addr,
  input  logic [BIT_LENGTH-1:0] wr_multiplier,
  input  logic [BIT_LENGTH-1:0] wr_multiplicand,
  input  logic start,
  input  logic [$clog2(MAX_GROUPS+1)-1:0] group_count,
  output logic busy,
  output logic err,
  output logic [INPUT_PORT_COUNT*BIT_LENGTH-1:0] multiplier_out,
  output logic [INPUT_PORT_COUNT*BIT_LENGTH-1:0] multiplicand_out,
  output logic [INPUT_PORT_COUNT-1:0] mStart,
  input  logic [INPUT_PORT_COUNT-1:0] mReady,
  output logic finalAdd,
  input  logic [2*BIT_LENGTH-1:0] cSum,
  input  logic cReady,
  output logic [2*BIT_LENGTH-1:0] result,
  output logic result_valid,
  input  logic result_ready
);

  localparam int Depth = INPUT_PORT_COUNT*MAX_GROUPS;
  localparam int AW = $clog2(Depth);
  localparam int GW = $clog2(MAX_GROUPS+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int BusW = INPUT_PORT_COUNT*BIT_LENGTH;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_M, FINAL, WAIT_C, HOLD
  } state_t;

  state_t state;
  logic [BIT_LENGTH-1:0] mulMem [Depth];
  logic [BIT_LENGTH-1:0] mcdMem [Depth];
  logic [GW-1:0] grpCnt;
  logic [GW-1:0] g;
  logic [GW-1:0] loadG;
  logic [AW-1:0] loadBase;
  logic [INPUT_PORT_COUNT-1:0] seen;
  logic [INPUT_PORT_COUNT-1:0] seenNext;
  logic [TW-1:0] wdog;
  logic [BusW-1:0] nextMul;
  logic [BusW-1:0] nextMcd;
  logic startOk;
  logic wdogDone;

  always_ff @(posedge Clk) begin
    if (wr_en && !busy && 32'(wr_addr) < Depth) begin
      mulMem[wr_addr] <= wr_multiplier;
      mcdMem[wr_addr] <= wr_multiplicand;
    end
  end

  // Group whose operands get latched on the next entry to LOAD
  assign loadG = (state == IDLE) ? '0 : g + 1'b1;
  assign loadBase = AW'(32'(loadG) * INPUT_PORT_COUNT);

  always_comb begin
    nextMul = '0;
    nextMcd = '0;
    for (int i = 0; i < INPUT_PORT_COUNT; i++) begin
      nextMul[i*BIT_LENGTH +: BIT_LENGTH] = mulMem[loadBase + AW'(i)];
      nextMcd[i*BIT_LENGTH +: BIT_LENGTH] = mcdMem[loadBase + AW'(i)];
    end
  end

  assign startOk = (group_count != '0) &&
                   (32'(group_count) <= MAX_GROUPS);
  assign seenNext = seen | mReady;
  assign wdogDone = (wdog == TW'(TIMEOUT-1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      busy <= 1'b0;
      err <= 1'b0;
      mStart <= '0;
      finalAdd <= 1'b0;
      result_valid <= 1'b0;
      result <= '0;
      multiplier_out <= '0;
      multiplicand_out <= '0;
      grpCnt <= '0;
      g <= '0;
      seen <= '0;
      wdog <= '0;
    end else begin
      mStart <= '0;
      finalAdd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && startOk) begin
            grpCnt <= group_count;
            g <= '0;
            err <= 1'b0;
            busy <= 1'b1;
            multiplier_out <= nextMul;
            multiplicand_out <= nextMcd;
            state <= LOAD;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          mStart <= '1;
          state <= START;
        end
        START: begin
          seen <= '0;
          wdog <= '0;
          state <= WAIT_M;
        end
        WAIT_M: begin
          seen <= seenNext;
          wdog <= wdog + 1'b1;
          if (&seenNext) begin
            if (g == grpCnt - 1'b1) begin
              finalAdd <= 1'b1;
              state <= FINAL;
            end else begin
              g <= g + 1'b1;
              multiplier_out <= nextMul;
              multiplicand_out <= nextMcd;
              state <= LOAD;
            end
          end else if (wdogDone) begin
            err <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        FINAL: begin
          wdog <= '0;
          state <= WAIT_C;
        end
        WAIT_C: begin
          wdog <= wdog + 1'b1;
          if (cReady) begin
            result <= cSum;
            result_valid <= 1'b1;
            state <= HOLD;
          end else if (wdogDone) begin
            err <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer: randomized jobs against a buffer/sum reference
// with a behavioural accelerator driving mReady/cReady/cSum.
module tb_conv_job_sequencer;
  localparam int IPC = 3;
  localparam int BL = 16;
  localparam int MG = 8;
  localparam int TO = 1024;
  localparam int DEPTH = IPC*MG;
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(MG+1);

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [BL-1:0] wr_multiplier = '0;
  logic [BL-1:0] wr_multiplicand = '0;
  logic start = 1'b0;
  logic [GW-1:0] group_count = '0;
  logic busy, err, finalAdd, result_valid;
  logic [IPC*BL-1:0] multiplier_out, multiplicand_out;
  logic [IPC-1:0] mStart;
  logic [IPC-1:0] mReady;
  logic [2*BL-1:0] cSum;
  logic cReady;
  logic [2*BL-1:0] result;
  logic result_ready = 1'b0;

  always #5 Clk = ~Clk;

  conv_job_sequencer #(
    .INPUT_PORT_COUNT(IPC), .BIT_LENGTH(BL),
    .MAX_GROUPS(MG), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_multiplier(wr_multiplier), .wr_multiplicand(wr_multiplicand),
    .start(start), .group_count(group_count), .busy(busy), .err(err),
    .multiplier_out(multiplier_out), .multiplicand_out(multiplicand_out),
    .mStart(mStart), .mReady(mReady), .finalAdd(finalAdd),
    .cSum(cSum), .cReady(cReady), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  int nChecks = 0;
  int nFails = 0;
  int cyc = 0;

  task automatic checkEq(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  logic [BL-1:0] refMul [DEPTH];
  logic [BL-1:0] refMcd [DEPTH];

  // Accelerator model knobs (written by stimulus only)
  int dly [IPC];
  bit pulseMode = 0;
  int cDly = 1;

  // Accelerator model state (written by the model only)
  int cd [IPC];
  int cCd = 0;
  bit watch = 0;
  bit fire;
  logic [31:0] acc = '0;
  int mStartCnt = 0;
  int finalCnt = 0;
  int opsMovedCnt = 0;
  int mStartBadCnt = 0;
  logic [IPC*BL-1:0] prevMul, prevMcd, snapMul, snapMcd;

  initial begin
    mReady = '0;
    cReady = 1'b0;
    cSum = '0;
    for (int i = 0; i < IPC; i++) cd[i] = 0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        for (int i = 0; i < IPC; i++) cd[i] = 0;
        cCd = 0;
        mReady = '0;
        cReady = 1'b0;
        watch = 0;
      end else begin
        if (!busy) acc = '0;
        if (watch && (multiplier_out !== snapMul ||
                      multiplicand_out !== snapMcd))
          opsMovedCnt++;
        if (mStart != '0) begin
          mStartCnt++;
          if (mStart != '1) mStartBadCnt++;
          if (multiplier_out !== prevMul || multiplicand_out !== prevMcd)
            opsMovedCnt++;
          for (int i = 0; i < IPC; i++) begin
            acc += 32'(multiplier_out[i*BL +: BL]) *
                   32'(multiplicand_out[i*BL +: BL]);
            cd[i] = dly[i];
          end
          mReady = '0;
          snapMul = multiplier_out;
          snapMcd = multiplicand_out;
          watch = 1;
        end else begin
          watch = 0;
          for (int i = 0; i < IPC; i++) begin
            fire = 0;
            if (cd[i] > 0) begin
              cd[i]--;
              fire = (cd[i] == 0);
            end
            if (cd[i] > 0) watch = 1;
            mReady[i] = pulseMode ? fire : (mReady[i] | fire);
          end
        end
        if (finalAdd) begin
          finalCnt++;
          cCd = cDly;
          cReady = 1'b0;
          cSum = $urandom;
        end else if (cCd > 0) begin
          cCd--;
          if (cCd == 0) begin
            cReady = 1'b1;
            cSum = acc;
          end
        end else begin
          cReady = 1'b0;
          cSum = $urandom;
        end
      end
      prevMul = multiplier_out;
      prevMcd = multiplicand_out;
    end
  end

  task automatic writeEntry(input int a, input logic [BL-1:0] m,
                            input logic [BL-1:0] c);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_multiplier = m;
    wr_multiplicand = c;
    if (a < DEPTH) begin
      refMul[a] = m;
      refMcd[a] = c;
    end
    @(negedge Clk);
    wr_en = 1'b0;
  endtask

  task automatic setDelays(input int d0, input int d1, input int d2,
                           input bit pm, input int cd0);
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    pulseMode = pm;
    cDly = cd0;
  endtask

  task automatic runJob(input int gc, input int rdyHold, input bit poke,
                        input bit wrBusy, input bit chkLat);
    logic [31:0] exp;
    logic [2*BL-1:0] held;
    int cS, waited, m0, f0, o0, b0;
    bit holdBad;
    exp = '0;
    for (int k = 0; k < gc*IPC; k++)
      exp += 32'(refMul[k]) * 32'(refMcd[k]);
    m0 = mStartCnt;
    f0 = finalCnt;
    o0 = opsMovedCnt;
    b0 = mStartBadCnt;
    @(negedge Clk);
    start = 1'b1;
    group_count = GW'(gc);
    @(negedge Clk);
    start = 1'b0;
    cS = cyc;
    checkEq("busyAfterStart", busy, 1);
    checkEq("errClearedOnStart", err, 0);
    if (wrBusy) begin
      wr_en = 1'b1;
      wr_addr = '0;
      wr_multiplier = 16'hdead;
      wr_multiplicand = 16'h0077;
      @(negedge Clk);
      wr_en = 1'b0;
    end
    waited = 0;
    while (!result_valid && waited < 3000) begin
      @(negedge Clk);
      waited++;
    end
    checkEq("resultValidSeen", result_valid, 1);
    if (chkLat) checkEq("latency", cyc - cS + 1, 3*gc + 3);
    checkEq("result", result, exp);
    held = result;
    holdBad = 0;
    for (int i = 0; i < rdyHold; i++) begin
      start = poke && (i == rdyHold/2);
      @(negedge Clk);
      if (!result_valid || result !== held) holdBad = 1;
    end
    start = poke;
    result_ready = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    result_ready = 1'b0;
    checkEq("holdStable", holdBad, 0);
    checkEq("idleAfterHandshake", {busy, result_valid}, 0);
    checkEq("resultRetained", result, held);
    @(negedge Clk);
    checkEq("startIgnoredInHold", busy, 0);
    checkEq("mStartPulses", mStartCnt - m0, gc);
    checkEq("finalAddPulses", finalCnt - f0, 1);
    checkEq("mStartAllLanes", mStartBadCnt - b0, 0);
    checkEq("operandsStable", opsMovedCnt - o0, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, "_busy"}, busy, 0);
    checkEq({tag, "_err"}, err, 0);
    checkEq({tag, "_mStart"}, mStart, 0);
    checkEq({tag, "_finalAdd"}, finalAdd, 0);
    checkEq({tag, "_rvalid"}, result_valid, 0);
    checkEq({tag, "_result"}, result, 0);
    checkEq({tag, "_mulOut"}, multiplier_out, 0);
    checkEq({tag, "_mcdOut"}, multiplicand_out, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL globalTimeout: simulation did not complete");
    $fatal(1, "hang");
  end

  initial begin
    int cF, waited, seenStarts, f0, gc;
    bit rvSeen;
    setDelays(1, 1, 1, 0, 1);
    repeat (3) @(negedge Clk);
    checkResetOutputs("reset");
    Rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) writeEntry(k, BL'(k+1), 16'd2);

    // Nominal: 2*(1+..+9) = 90 in 12 cycles
    runJob(3, 0, 0, 0, 1);
    checkEq("nominal90", result, 90);

    // Illegal counts
    for (int n = 0; n < 2; n++) begin
      start = 1'b1;
      group_count = (n == 0) ? GW'(0) : GW'(MG+1);
      @(negedge Clk);
      start = 1'b0;
      checkEq("illegalErr", err, 1);
      checkEq("illegalIdle", busy, 0);
    end

    // Staggered single-cycle mReady pulses
    setDelays(1, 4, 7, 1, 1);
    runJob(3, 0, 0, 0, 0);

    // Backpressure with start poked during HOLD
    setDelays(2, 1, 3, 0, 2);
    runJob(2, 20, 1, 0, 0);

    // Final accumulate never returns
    setDelays(1, 1, 1, 0, 0);
    start = 1'b1;
    group_count = GW'(1);
    @(negedge Clk);
    start = 1'b0;
    waited = 0;
    while (!finalAdd && waited < 100) begin
      @(negedge Clk);
      waited++;
    end
    cF = cyc;
    rvSeen = 0;
    waited = 0;
    while (busy && waited < TO + 50) begin
      @(negedge Clk);
      if (result_valid) rvSeen = 1;
      waited++;
    end
    checkEq("timeoutCycles", cyc - cF, TO + 1);
    checkEq("timeoutErr", err, 1);
    checkEq("timeoutNoValid", rvSeen, 0);
    setDelays(1, 2, 1, 0, 1);
    runJob(1, 0, 0, 0, 0);

    // Reset while waiting on group 2
    setDelays(1, 8, 8, 0, 1);
    f0 = finalCnt;
    start = 1'b1;
    group_count = GW'(3);
    @(negedge Clk);
    start = 1'b0;
    seenStarts = 0;
    waited = 0;
    while (seenStarts < 2 && waited < 100) begin
      @(negedge Clk);
      if (mStart != '0) seenStarts++;
      waited++;
    end
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checkResetOutputs("midReset");
    @(negedge Clk);
    checkEq("postReset_mStart", mStart, 0);
    checkEq("postReset_finalAdd", finalAdd, 0);
    Rst = 1'b0;
    @(negedge Clk);
    checkEq("postRelease_strobes", {mStart, finalAdd}, 0);
    checkEq("noFinalAddOnReset", finalCnt - f0, 0);
    setDelays(1, 1, 1, 0, 1);
    runJob(3, 0, 0, 0, 1);

    // Write while busy is dropped; out-of-range writes are dropped
    runJob(3, 0, 0, 1, 0);
    writeEntry(DEPTH, 16'hffff, 16'hffff);
    writeEntry(31, 16'hbeef, 16'h1234);
    runJob(MG, 1, 0, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      for (int w = 0; w < 4; w++)
        writeEntry($urandom_range(31), BL'($urandom), BL'($urandom));
      setDelays($urandom_range(1, 6), $urandom_range(1, 6),
                $urandom_range(1, 6), 1'($urandom_range(1)),
                $urandom_range(1, 4));
      gc = $urandom_range(1, MG);
      runJob(gc, $urandom_range(3), 1'($urandom_range(1)),
             1'($urandom_range(1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end
endmodule
